// File: rtl/controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
package controller_pkg;

   localparam int unsigned ALU_OP_BITS = 5;
   localparam int unsigned CNT_W       = 8;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_t;

   typedef enum logic [2:0] {
      F3_ADD_SUB = 3'd0,
      F3_SLL     = 3'd1,
      F3_SLT     = 3'd2,
      F3_SLTU    = 3'd3,
      F3_XOR     = 3'd4,
      F3_SRL_SRA = 3'd5,
      F3_OR      = 3'd6,
      F3_AND     = 3'd7
   } funct3_t;

   typedef enum logic [ALU_OP_BITS-1:0] {
      ALU_ADD = 5'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
      ALU_MUL = 5'd10, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_op_t;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [1:0] A_RS1  = 2'd0;
   localparam logic [1:0] A_PC   = 2'd1;
   localparam logic [1:0] A_ZERO = 2'd2;
   localparam logic [1:0] B_RS2  = 2'd0;
   localparam logic [1:0] B_IMM  = 2'd1;
   localparam logic [1:0] B_FOUR = 2'd2;
   localparam logic       ADDR_PC   = 1'b0;
   localparam logic       ADDR_ALU  = 1'b1;
   localparam logic       PCN_PLUS4 = 1'b0;
   localparam logic       PCN_ALU   = 1'b1;
   localparam logic [1:0] RD_ALU = 2'd0;
   localparam logic [1:0] RD_MEM = 2'd1;
   localparam logic [1:0] RD_PC4 = 2'd2;

   // Base integer op from funct3; alt selects SUB/SRA.
   function automatic alu_op_t base_op(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         default:    op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational opcode/funct decode to ALU op plus legality.
// Optional macro CONTROLLER_MULDIV_EN enables the M-extension R-type encodings.
module alu_decoder
   import controller_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output alu_op_t    alu_op_o,
   output logic       illegal_o
);

   // Decode ALU operation and flag unsupported encodings.
   always_comb begin
      alu_op_o  = ALU_ADD;
      illegal_o = 1'b0;
      case (opcode_i)
         OPC_OP: begin
            if (funct7_i == 7'b0000000) begin
               alu_op_o = base_op(funct3_i, 1'b0);
            end else if (funct7_i == 7'b0100000 &&
                         (funct3_i == F3_ADD_SUB || funct3_i == F3_SRL_SRA)) begin
               alu_op_o = base_op(funct3_i, 1'b1);
`ifdef CONTROLLER_MULDIV_EN
            end else if (funct7_i == 7'b0000001) begin
               alu_op_o = alu_op_t'(ALU_OP_BITS'(ALU_MUL) + ALU_OP_BITS'(funct3_i));
`endif
            end else begin
               illegal_o = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            // Immediate bits sit in funct7 except for shifts, so only SRAI honours bit 5.
            if (funct3_i == F3_SLL) begin
               alu_op_o  = ALU_SLL;
               illegal_o = (funct7_i != 7'b0000000);
            end else if (funct3_i == F3_SRL_SRA) begin
               alu_op_o  = base_op(funct3_i, funct7_i[5]);
               illegal_o = (funct7_i != 7'b0000000) && (funct7_i != 7'b0100000);
            end else begin
               alu_op_o = base_op(funct3_i, 1'b0);
            end
         end
         OPC_LOAD:   illegal_o = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
         OPC_STORE:  illegal_o = (funct3_i > 3'd2);
         OPC_BRANCH: illegal_o = (funct3_i == 3'd2) || (funct3_i == 3'd3);
         OPC_JALR:   illegal_o = (funct3_i != 3'd0);
         OPC_LUI, OPC_AUIPC, OPC_JAL: illegal_o = 1'b0;
         default:    illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory timeout trap.
// Optional macro CONTROLLER_MULDIV_EN (passed through to alu_decoder).
module multicycle_controller
   import controller_pkg::*;
#(
   parameter int unsigned ALU_OP_W    = 5,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic [6:0]          funct7,
   input  logic                branch_taken,
   input  logic                mem_ready,
   output logic [ALU_OP_W-1:0] alu_control,
   output logic [1:0]          alu_a_sel,
   output logic [1:0]          alu_b_sel,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_addr_sel,
   output logic                ir_we,
   output logic                pc_we,
   output logic                pc_next_sel,
   output logic                reg_we,
   output logic [1:0]          reg_data_sel,
   output logic                illegal,
   output logic                mem_fault,
   output logic [2:0]          state_o
);

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             fault_q, fault_d;
   alu_op_t          dec_op, alu_op;
   logic             dec_illegal;
   logic [1:0]       ex_a, ex_b;

   alu_decoder u_dec (
      .opcode_i  (opcode),
      .funct3_i  (funct3),
      .funct7_i  (funct7),
      .alu_op_o  (dec_op),
      .illegal_o (dec_illegal)
   );

   // State, wait counter and sticky flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         fault_q   <= fault_d;
      end
   end

   // Next state and control outputs; everything held inactive during reset.
   always_comb begin
      state_d      = state_q;
      illegal_d    = illegal_q;
      fault_d      = fault_q;
      alu_op       = ALU_ADD;
      alu_a_sel    = A_RS1;
      alu_b_sel    = B_RS2;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = ADDR_PC;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_next_sel  = PCN_PLUS4;
      reg_we       = 1'b0;
      reg_data_sel = RD_ALU;

      // Operand selection shared by EXEC and WB (WB recomputes the ALU result).
      case (opcode)
         OPC_OP:                          begin ex_a = A_RS1;  ex_b = B_RS2; end
         OPC_LUI:                         begin ex_a = A_ZERO; ex_b = B_IMM; end
         OPC_AUIPC, OPC_BRANCH, OPC_JAL:  begin ex_a = A_PC;   ex_b = B_IMM; end
         default:                         begin ex_a = A_RS1;  ex_b = B_IMM; end
      endcase

      if (!reset) begin
         case (state_q)
            FETCH: begin
               mem_req = 1'b1;
               ir_we   = mem_ready;
               if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
               if (dec_illegal) begin
                  state_d   = TRAP;
                  illegal_d = 1'b1;
               end else begin
                  state_d = EXEC;
               end
            end
            EXEC: begin
               alu_op    = dec_op;
               alu_a_sel = ex_a;
               alu_b_sel = ex_b;
               if (opcode == OPC_BRANCH) begin
                  pc_we       = 1'b1;
                  pc_next_sel = branch_taken;
                  state_d     = FETCH;
               end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                  state_d = MEM;
               end else begin
                  state_d = WB;
               end
            end
            MEM: begin
               mem_req      = 1'b1;
               mem_addr_sel = ADDR_ALU;
               mem_we       = (opcode == OPC_STORE);
               alu_a_sel    = A_RS1;
               alu_b_sel    = B_IMM;
               if (mem_ready) begin
                  if (opcode == OPC_STORE) begin
                     pc_we   = 1'b1;
                     state_d = FETCH;
                  end else begin
                     state_d = WB;
                  end
               end
            end
            WB: begin
               alu_op    = dec_op;
               alu_a_sel = ex_a;
               alu_b_sel = ex_b;
               reg_we    = 1'b1;
               pc_we     = 1'b1;
               if (opcode == OPC_LOAD) begin
                  reg_data_sel = RD_MEM;
               end else if (opcode == OPC_JAL || opcode == OPC_JALR) begin
                  reg_data_sel = RD_PC4;
                  pc_next_sel  = PCN_ALU;
               end
               state_d = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
         endcase

         // A request left waiting through its last allowed cycle traps.
         if (mem_req && !mem_ready && cnt_q == CNT_LIMIT) begin
            state_d = TRAP;
            fault_d = 1'b1;
         end
      end

      cnt_d = (mem_req && !mem_ready && state_d == state_q) ? CNT_W'(cnt_q + 1'b1) : '0;
   end

   assign alu_control = ALU_OP_W'(alu_op);
   assign illegal     = illegal_q;
   assign mem_fault   = fault_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors
// go through a scoreboard queue and are compared on the falling edge.
module tb_multicycle_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       branch_taken;
   logic       mem_ready;
   logic [4:0] alu_control;
   logic [1:0] alu_a_sel, alu_b_sel, reg_data_sel;
   logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_next_sel, reg_we;
   logic       illegal, mem_fault;
   logic [2:0] state_o;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic        exp_ill = 1'b0;
   logic        exp_flt = 1'b0;
   logic [22:0] sb[$];

   multicycle_controller #(.ALU_OP_W(5), .MEM_TIMEOUT(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .opcode       (opcode),
      .funct3       (funct3),
      .funct7       (funct7),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .alu_control  (alu_control),
      .alu_a_sel    (alu_a_sel),
      .alu_b_sel    (alu_b_sel),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_next_sel  (pc_next_sel),
      .reg_we       (reg_we),
      .reg_data_sel (reg_data_sel),
      .illegal      (illegal),
      .mem_fault    (mem_fault),
      .state_o      (state_o)
   );

   always #5 clock = ~clock;

   function automatic logic [22:0] mk(input logic [2:0] st, input logic [4:0] alu,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic req, input logic we, input logic asel,
                                      input logic irwe, input logic pcwe, input logic pcn,
                                      input logic regwe, input logic [1:0] rd);
      return {st, alu, a, b, req, we, asel, irwe, pcwe, pcn, regwe, rd, exp_ill, exp_flt};
   endfunction

   function automatic logic [22:0] e_f(input logic rdy);
      return mk(3'd0, 5'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 2'd0);
   endfunction
   function automatic logic [22:0] e_d();
      return mk(3'd1, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
   endfunction
   function automatic logic [22:0] e_e(input logic [4:0] alu, input logic [1:0] a,
                                       input logic [1:0] b, input logic pcwe, input logic pcn);
      return mk(3'd2, alu, a, b, 1'b0, 1'b0, 1'b0, 1'b0, pcwe, pcn, 1'b0, 2'd0);
   endfunction
   function automatic logic [22:0] e_m(input logic we, input logic rdy);
      return mk(3'd3, 5'd0, 2'd0, 2'd1, 1'b1, we, 1'b1, 1'b0, we & rdy, 1'b0, 1'b0, 2'd0);
   endfunction
   function automatic logic [22:0] e_w(input logic [4:0] alu, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rd, input logic pcn);
      return mk(3'd4, alu, a, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pcn, 1'b1, rd);
   endfunction
   // Idle outputs with a given visible state (TRAP, or any state during reset).
   function automatic logic [22:0] e_idle(input logic [2:0] st);
      return mk(st, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
   endfunction

   // One clock: drive inputs, queue the expectation, compare on the falling edge.
   task automatic cyc(input logic rst, input logic rdy, input logic bt,
                      input logic [22:0] exp, input string tag);
      logic [22:0] obs, want;
      reset        = rst;
      mem_ready    = rdy;
      branch_taken = bt;
      sb.push_back(exp);
      @(negedge clock);
      obs = {state_o, alu_control, alu_a_sel, alu_b_sel, mem_req, mem_we, mem_addr_sel,
             ir_we, pc_we, pc_next_sel, reg_we, reg_data_sel, illegal, mem_fault};
      want = sb.pop_front();
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic set_ins(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
      opcode = opc;
      funct3 = f3;
      funct7 = f7;
   endtask

   // Zero-wait instruction that goes FETCH/DECODE/EXEC/WB.
   task automatic run_wb(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] alu, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] rd, input logic pcn);
      set_ins(opc, f3, f7);
      cyc(1'b0, 1'b1, 1'b0, e_f(1'b1), {tag, "_fetch"});
      cyc(1'b0, 1'b1, 1'b0, e_d(), {tag, "_decode"});
      cyc(1'b0, 1'b1, 1'b0, e_e(alu, a, b, 1'b0, 1'b0), {tag, "_exec"});
      cyc(1'b0, 1'b1, 1'b0, e_w(alu, a, b, rd, pcn), {tag, "_wb"});
   endtask

   initial begin
      reset = 1'b1;
      mem_ready = 1'b0;
      branch_taken = 1'b0;
      set_ins(7'b0110011, 3'd0, 7'd0);
      @(posedge clock);
      #1;
      cyc(1'b1, 1'b1, 1'b0, e_idle(3'd0), "reset");

      run_wb("add",   7'b0110011, 3'd0, 7'b0000000, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      run_wb("sub",   7'b0110011, 3'd0, 7'b0100000, 5'd1, 2'd0, 2'd0, 2'd0, 1'b0);
      run_wb("srai",  7'b0010011, 3'd5, 7'b0100000, 5'd7, 2'd0, 2'd1, 2'd0, 1'b0);
      run_wb("addi",  7'b0010011, 3'd0, 7'b0100000, 5'd0, 2'd0, 2'd1, 2'd0, 1'b0);
      run_wb("xor",   7'b0110011, 3'd4, 7'b0000000, 5'd5, 2'd0, 2'd0, 2'd0, 1'b0);
      run_wb("lui",   7'b0110111, 3'd0, 7'b0000000, 5'd0, 2'd2, 2'd1, 2'd0, 1'b0);
      run_wb("auipc", 7'b0010111, 3'd0, 7'b0000000, 5'd0, 2'd1, 2'd1, 2'd0, 1'b0);
      run_wb("jal",   7'b1101111, 3'd0, 7'b0000000, 5'd0, 2'd1, 2'd1, 2'd2, 1'b1);
      run_wb("jalr",  7'b1100111, 3'd0, 7'b0000000, 5'd0, 2'd0, 2'd1, 2'd2, 1'b1);

      // LW with three wait cycles in MEM.
      set_ins(7'b0000011, 3'd2, 7'd0);
      cyc(1'b0, 1'b1, 1'b0, e_f(1'b1), "lw_fetch");
      cyc(1'b0, 1'b1, 1'b0, e_d(), "lw_decode");
      cyc(1'b0, 1'b1, 1'b0, e_e(5'd0, 2'd0, 2'd1, 1'b0, 1'b0), "lw_exec");
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, e_m(1'b0, 1'b0), "lw_mem_wait");
      cyc(1'b0, 1'b1, 1'b0, e_m(1'b0, 1'b1), "lw_mem_done");
      cyc(1'b0, 1'b1, 1'b0, e_w(5'd0, 2'd0, 2'd1, 2'd1, 1'b0), "lw_wb");

      // SW zero-wait.
      set_ins(7'b0100011, 3'd2, 7'd0);
      cyc(1'b0, 1'b1, 1'b0, e_f(1'b1), "sw_fetch");
      cyc(1'b0, 1'b1, 1'b0, e_d(), "sw_decode");
      cyc(1'b0, 1'b1, 1'b0, e_e(5'd0, 2'd0, 2'd1, 1'b0, 1'b0), "sw_exec");
      cyc(1'b0, 1'b1, 1'b0, e_m(1'b1, 1'b1), "sw_mem");

      // BEQ taken, then not taken.
      for (int t = 1; t >= 0; t--) begin
         set_ins(7'b1100011, 3'd0, 7'd0);
         cyc(1'b0, 1'b1, 1'(t), e_f(1'b1), "beq_fetch");
         cyc(1'b0, 1'b1, 1'(t), e_d(), "beq_decode");
         cyc(1'b0, 1'b1, 1'(t), e_e(5'd0, 2'd1, 2'd1, 1'b1, 1'(t)), "beq_exec");
      end

      // Reset asserted while a store waits in MEM.
      set_ins(7'b0100011, 3'd0, 7'd0);
      cyc(1'b0, 1'b1, 1'b0, e_f(1'b1), "rst_sw_fetch");
      cyc(1'b0, 1'b1, 1'b0, e_d(), "rst_sw_decode");
      cyc(1'b0, 1'b1, 1'b0, e_e(5'd0, 2'd0, 2'd1, 1'b0, 1'b0), "rst_sw_exec");
      cyc(1'b0, 1'b0, 1'b0, e_m(1'b1, 1'b0), "rst_sw_mem");
      cyc(1'b1, 1'b0, 1'b0, e_idle(3'd3), "rst_sw_reset");
      run_wb("post_rst_add", 7'b0110011, 3'd0, 7'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0);

      // Ready arrives on the 16th request cycle: no fault.
      set_ins(7'b0110011, 3'd0, 7'd0);
      for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, e_f(1'b0), "late_fetch_wait");
      cyc(1'b0, 1'b1, 1'b0, e_f(1'b1), "late_fetch_ready");
      cyc(1'b0, 1'b1, 1'b0, e_d(), "late_decode");
      cyc(1'b0, 1'b1, 1'b0, e_e(5'd0, 2'd0, 2'd0, 1'b0, 1'b0), "late_exec");
      cyc(1'b0, 1'b1, 1'b0, e_w(5'd0, 2'd0, 2'd0, 2'd0, 1'b0), "late_wb");

      // Illegal opcode traps and stays trapped until reset.
      set_ins(7'b0001111, 3'd0, 7'd0);
      cyc(1'b0, 1'b1, 1'b0, e_f(1'b1), "ill_fetch");
      cyc(1'b0, 1'b1, 1'b0, e_d(), "ill_decode");
      exp_ill = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, e_idle(3'd5), "ill_trap");
      cyc(1'b1, 1'b0, 1'b0, e_idle(3'd5), "ill_reset");
      exp_ill = 1'b0;

      // Fetch never answered: fault after 16 request cycles.
      set_ins(7'b0110011, 3'd0, 7'd0);
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, e_f(1'b0), "to_fetch_wait");
      exp_flt = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, e_idle(3'd5), "to_trap");
      cyc(1'b1, 1'b0, 1'b0, e_idle(3'd5), "to_reset");
      exp_flt = 1'b0;

      // M-extension R-type (DIV) only decodes when the option is built in.
      set_ins(7'b0110011, 3'd4, 7'b0000001);
      cyc(1'b0, 1'b1, 1'b0, e_f(1'b1), "div_fetch");
      cyc(1'b0, 1'b1, 1'b0, e_d(), "div_decode");
`ifdef CONTROLLER_MULDIV_EN
      cyc(1'b0, 1'b1, 1'b0, e_e(5'd14, 2'd0, 2'd0, 1'b0, 1'b0), "div_exec");
      cyc(1'b0, 1'b1, 1'b0, e_w(5'd14, 2'd0, 2'd0, 2'd0, 1'b0), "div_wb");
      cyc(1'b1, 1'b0, 1'b0, e_idle(3'd0), "div_reset");
`else
      exp_ill = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, e_idle(3'd5), "div_trap");
      cyc(1'b1, 1'b0, 1'b0, e_idle(3'd5), "div_reset");
      exp_ill = 1'b0;
`endif
      cyc(1'b0, 1'b0, 1'b0, e_f(1'b0), "final_fetch");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle RV32I control FSM. Next generation of the single-cycle combinational controller. Sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath and a ready-handshaked unified memory port. Drives ALU op, operand muxes, register-file/PC/IR write enables, and trap flags. Sits between the instruction register decode fields and the datapath.

Parameters:
ALU_OP_W, 5, width of alu_control; must be >=5.
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before fault; range 1..255.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  7  instruction[6:0] from IR
funct3  in  3  instruction[14:12]
funct7  in  7  instruction[31:25]
branch_taken  in  1  branch comparator result for current funct3
mem_ready  in  1  memory completes the request this cycle
alu_control  out  ALU_OP_W  ALU operation (pkg alu_op_t)
alu_a_sel  out  2  0=rs1, 1=pc, 2=zero
alu_b_sel  out  2  0=rs2, 1=imm, 2=const 4
mem_req  out  1  memory request valid
mem_we  out  1  store when 1 (qualified by mem_req)
mem_addr_sel  out  1  0=pc (fetch), 1=alu_result
ir_we  out  1  load IR from memory data
pc_we  out  1  update PC
pc_next_sel  out  1  0=pc+4, 1=alu_result
reg_we  out  1  register-file write
reg_data_sel  out  2  0=alu, 1=mem data, 2=pc+4
illegal  out  1  sticky: undecodable instruction
mem_fault  out  1  sticky: memory timeout
state_o  out  3  current state, debug

Behaviour:
- Reset: state=FETCH, wait counter=0, illegal=mem_fault=0. During the reset cycle all enables (mem_req, ir_we, pc_we, reg_we, mem_we) are 0. alu_control=ADD and all selects are 0.
- Outputs are Moore/Mealy combinational from state, opcode, branch_taken and mem_ready. Only state, counter and the sticky flags are registered.
- FETCH: mem_req=1, mem_addr_sel=0. ir_we=mem_ready. On mem_ready -> DECODE, else stay.
- DECODE: one cycle. Illegal opcode or funct combination -> TRAP with illegal=1. Otherwise -> EXEC.
- EXEC, per opcode:
  - OP (0110011): a=rs1, b=rs2. funct7[5] selects SUB/SRA. -> WB.
  - OP_IMM (0010011): a=rs1, b=imm. funct7[5] is honoured only for funct3=101 (SRAI). -> WB.
  - LUI (0110111): a=zero, b=imm, ADD -> WB.
  - AUIPC (0010111): a=pc, b=imm, ADD -> WB.
  - LOAD (0000011) and STORE (0100011): a=rs1, b=imm, ADD -> MEM.
  - BRANCH (1100011): a=pc, b=imm, ADD. pc_we=1. pc_next_sel=branch_taken. -> FETCH.
  - JAL (1101111): a=pc, b=imm. JALR (1100111): a=rs1, b=imm. Both ADD, -> WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE). Hold until mem_ready. Store completes with pc_we=1, pc+4, -> FETCH. Load -> WB.
- WB: reg_we=1, pc_we=1.
  - reg_data_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_next_sel=1 only for JAL/JALR. For these the ALU recomputes the target (same selects as EXEC). JALR target LSB clearing is done in the datapath.
  - -> FETCH.
- Timeout:
  - Counter increments each cycle mem_req=1 and mem_ready=0. It clears on mem_ready or on a state change.
  - When counter reaches MEM_TIMEOUT-1 with mem_ready still 0 -> TRAP, mem_fault=1, mem_req drops the next cycle.
  - mem_ready in the same cycle as the limit wins: no fault.
- TRAP: all enables 0. Stays until reset. The flags stay set.
- Latency with zero-wait memory: R/I/U/JAL = 4 cycles, LOAD = 5, STORE = 4, BRANCH = 3.
- Reset mid-access: FSM returns to FETCH and drops mem_req in the reset cycle. No partial write enables are issued.

Optional Feature:
- Macro: CONTROLLER_MULDIV_EN.
- Defined: OP with funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (by funct3), a=rs1, b=rs2, -> WB.
- Undefined: that encoding is illegal -> TRAP.

Decomposition:
- controller_pkg holds: opcode_t, funct3_t, alu_op_t, state_t (FETCH, DECODE, EXEC, MEM, WB, TRAP), and select-encoding constants.
- alu_op_t values: ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL..REMU=10..17.
- One sub-module, alu_decoder: combinational opcode/funct3/funct7 -> alu_op and illegal. It is shared by DECODE (legality check) and EXEC (op selection).

Test Plan:
- ADD (opcode 0110011, f3=000, f7=0000000), mem_ready=1 in FETCH -> 4 cycles. alu_control=ADD in EXEC. reg_we=1 with reg_data_sel=0 in WB. pc_we pulses once.
- SUB (f7=0100000) and SRAI (0010011, f3=101, f7=0100000) -> SUB and SRA. ADDI with f7=0100000 -> ADD.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, mem_addr_sel=1, mem_we=0, then WB with reg_data_sel=1. Total 8 cycles.
- BEQ with branch_taken=1 -> pc_we=1, pc_next_sel=1 in EXEC, back to FETCH after 3 cycles. With branch_taken=0 -> pc_next_sel=0, reg_we never asserted.
- FETCH with mem_ready held 0, MEM_TIMEOUT=16 -> mem_fault=1 and state TRAP after 16 request cycles, no enables afterwards. mem_ready on the 16th request cycle -> no fault.
- Opcode 0001111 -> illegal=1, TRAP. Reset asserted mid-MEM store -> mem_we=0 the same cycle, FETCH after release. f7=0000001 R-type traps unless CONTROLLER_MULDIV_EN is defined.
